// File: rtl/fpga_reg_arbiter.sv
// Round-robin arbiter that shares the 4 x 32-bit FPGA register slave between two Avalon-MM masters.
// Each transaction runs IDLE -> ACCESS -> DONE, so the slave sees exactly one registered strobe cycle.
module fpga_reg_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_waitrequest,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_waitrequest,
   output logic [ADDR_W-1:0] avs_address,
   output logic              avs_chipselect,
   output logic              avs_write_n,
   output logic [DATA_W-1:0] avs_writedata,
   input  logic [DATA_W-1:0] avs_readdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              grant_q, grant_d;
   logic              is_write_q, is_write_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
   logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
   logic              cs_q, cs_d;
   logic              write_n_q, write_n_d;
   logic              m0_req, m1_req, grant_sel;

   assign m0_req = m0_read | m0_write;
   assign m1_req = m1_read | m1_write;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      is_write_d   = is_write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      m0_rdata_d   = m0_rdata_q;
      m1_rdata_d   = m1_rdata_q;
      cs_d         = cs_q;
      write_n_d    = write_n_q;
      // Contention goes to whoever did not win last time; otherwise the lone requester wins.
      grant_sel    = (m0_req && m1_req) ? ~last_grant_q : m1_req;
      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               grant_d      = grant_sel;
               last_grant_d = grant_sel;
               is_write_d   = grant_sel ? m1_write : m0_write;
               addr_d       = grant_sel ? m1_address : m0_address;
               wdata_d      = grant_sel ? m1_writedata : m0_writedata;
               cs_d         = 1'b1;
               write_n_d    = grant_sel ? ~m1_write : ~m0_write;
               state_d      = ACCESS;
            end
         end
         ACCESS: begin
            if (!is_write_q) begin
               if (grant_q) m1_rdata_d = avs_readdata;
               else         m0_rdata_d = avs_readdata;
            end
            cs_d      = 1'b0;
            write_n_d = 1'b1;
            state_d   = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         is_write_q   <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         m0_rdata_q   <= '0;
         m1_rdata_q   <= '0;
         cs_q         <= 1'b0;
         write_n_q    <= 1'b1;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         is_write_q   <= is_write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         m0_rdata_q   <= m0_rdata_d;
         m1_rdata_q   <= m1_rdata_d;
         cs_q         <= cs_d;
         write_n_q    <= write_n_d;
      end
   end

   // Reset masks the strobe in the same cycle so an ACCESS caught by reset never commits.
   assign avs_chipselect = cs_q & ~reset;
   assign avs_write_n    = write_n_q | reset;
   assign avs_address    = addr_q;
   assign avs_writedata  = wdata_q;
   assign m0_readdata    = m0_rdata_q;
   assign m1_readdata    = m1_rdata_q;
   assign m0_waitrequest = ~((state_q == DONE) && !grant_q);
   assign m1_waitrequest = ~((state_q == DONE) && grant_q);

endmodule

// File: tb/tb_fpga_reg_arbiter.sv
// Bench for fpga_reg_arbiter: directed cycle table, alternation sequence, then random traffic vs a timestamp model.
module tb_fpga_reg_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  m0_address, m1_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_waitrequest, m1_waitrequest;
   logic [1:0]  avs_address;
   logic        avs_chipselect, avs_write_n;
   logic [31:0] avs_writedata, avs_readdata;

   logic [31:0] slave_mem [4];

   always #5 clk = ~clk;

   fpga_reg_arbiter #(.DATA_W(32), .ADDR_W(2)) dut (
      .clk(clk), .reset(rst),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
      .avs_address(avs_address), .avs_chipselect(avs_chipselect), .avs_write_n(avs_write_n),
      .avs_writedata(avs_writedata), .avs_readdata(avs_readdata)
   );

   // Register slave: combinational read, write on the edge closing a selected write cycle.
   assign avs_readdata = slave_mem[avs_address];
   always_ff @(posedge clk) begin
      if (avs_chipselect && !avs_write_n) slave_mem[avs_address] <= avs_writedata;
   end

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      else n_pass++;
   endtask

   // Transaction-level model: a grant at cycle t strobes the slave at t+1, completes at t+2,
   // and the arbiter is free again at t+3.
   int          m_free_at = 0, m_done_at = 0;
   bit          m_pend = 0, m_owner = 0, m_iswr = 0, m_last = 1;
   logic [1:0]  m_addr = 0;
   logic [31:0] m_wdata = 0;
   logic [31:0] m_rd [2] = '{0, 0};
   logic [31:0] m_mem [4] = '{0, 0, 0, 0};

   task automatic model_step();
      bit r0, r1, g;
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      if (rst) begin
         m_pend = 0; m_free_at = cyc + 1; m_last = 1;
         m_rd[0] = 0; m_rd[1] = 0; m_addr = 0; m_wdata = 0;
         return;
      end
      if (m_pend && cyc == m_done_at - 1) begin
         if (m_iswr) m_mem[m_addr] = m_wdata;
         else        m_rd[m_owner] = m_mem[m_addr];
      end
      if (m_pend && cyc == m_done_at) m_pend = 0;
      if (cyc >= m_free_at && (r0 || r1)) begin
         g = (r0 && r1) ? !m_last : r1;
         m_last = g; m_owner = g; m_pend = 1;
         m_done_at = cyc + 2; m_free_at = cyc + 3;
         m_iswr  = g ? m1_write : m0_write;
         m_addr  = g ? m1_address : m0_address;
         m_wdata = g ? m1_writedata : m0_writedata;
      end
   endtask

   task automatic model_check();
      bit ecs;
      ecs = m_pend && (cyc == m_done_at - 1) && !rst;
      chk("rnd m0_waitrequest", {31'b0, m0_waitrequest}, {31'b0, !(m_pend && cyc == m_done_at && !m_owner)});
      chk("rnd m1_waitrequest", {31'b0, m1_waitrequest}, {31'b0, !(m_pend && cyc == m_done_at && m_owner)});
      chk("rnd avs_chipselect", {31'b0, avs_chipselect}, {31'b0, ecs});
      chk("rnd avs_write_n", {31'b0, avs_write_n}, {31'b0, !(ecs && m_iswr)});
      chk("rnd avs_address", {30'b0, avs_address}, {30'b0, m_addr});
      chk("rnd avs_writedata", avs_writedata, m_wdata);
      chk("rnd m0_readdata", m0_readdata, m_rd[0]);
      chk("rnd m1_readdata", m1_readdata, m_rd[1]);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
   endtask

   task automatic drive(input logic r, input logic [1:0] op0, input logic [1:0] a0, input logic [31:0] d0,
                        input logic [1:0] op1, input logic [1:0] a1, input logic [31:0] d1);
      rst = r;
      m0_read = op0[0]; m0_write = op0[1]; m0_address = a0; m0_writedata = d0;
      m1_read = op1[0]; m1_write = op1[1]; m1_address = a1; m1_writedata = d1;
   endtask

   typedef struct {
      logic rst; logic [1:0] op0, a0; logic [31:0] d0; logic [1:0] op1, a1; logic [31:0] d1;
      logic chk; logic ew0, ew1, ecs, ewn; logic [1:0] eaddr; logic [31:0] erd0, erd1;
   } vec_t;

   function automatic vec_t mk(logic r, logic [1:0] op0, logic [1:0] a0, logic [31:0] d0,
                               logic [1:0] op1, logic [1:0] a1, logic [31:0] d1, logic c,
                               logic ew0, logic ew1, logic ecs, logic ewn, logic [1:0] eaddr,
                               logic [31:0] erd0, logic [31:0] erd1);
      vec_t v;
      v.rst = r; v.op0 = op0; v.a0 = a0; v.d0 = d0; v.op1 = op1; v.a1 = a1; v.d1 = d1;
      v.chk = c; v.ew0 = ew0; v.ew1 = ew1; v.ecs = ecs; v.ewn = ewn; v.eaddr = eaddr;
      v.erd0 = erd0; v.erd1 = erd1;
      return v;
   endfunction

   localparam logic [31:0] B = 32'hDEADBEEF;
   localparam logic [31:0] A = 32'hA5A5A5A5;

   vec_t vecs [36];
   int   order [$];
   int   when [$];
   bit   act [2];
   logic [1:0]  rop [2];
   logic [1:0]  radr [2];
   logic [31:0] rdat [2];

   initial begin
      for (int i = 0; i < 4; i++) slave_mem[i] = 32'h0;
      // rst, m0 op/addr/data, m1 op/addr/data, check | wr0 wr1 cs wn addr rd0 rd1  (op: 1=read 2=write 3=both)
      vecs[0]  = mk(1, 0,0,0,        0,0,0,      0, 1,1,0,1, 0, 0,     0);
      vecs[1]  = mk(1, 0,0,0,        0,0,0,      1, 1,1,0,1, 0, 0,     0);
      vecs[2]  = mk(0, 2,2,B,        0,0,0,      1, 1,1,0,1, 0, 0,     0);
      vecs[3]  = mk(0, 2,2,B,        0,0,0,      1, 1,1,1,0, 2, 0,     0);
      vecs[4]  = mk(0, 2,2,B,        0,0,0,      1, 0,1,0,1, 2, 0,     0);
      vecs[5]  = mk(0, 1,2,0,        0,0,0,      1, 1,1,0,1, 2, 0,     0);
      vecs[6]  = mk(0, 1,2,0,        0,0,0,      1, 1,1,1,1, 2, 0,     0);
      vecs[7]  = mk(0, 1,2,0,        0,0,0,      1, 0,1,0,1, 2, B,     0);
      vecs[8]  = mk(1, 0,0,0,        0,0,0,      1, 1,1,0,1, 2, B,     0);
      vecs[9]  = mk(0, 2,0,32'h11,   2,0,32'h22, 1, 1,1,0,1, 0, 0,     0);
      vecs[10] = mk(0, 2,0,32'h11,   2,0,32'h22, 1, 1,1,1,0, 0, 0,     0);
      vecs[11] = mk(0, 2,0,32'h11,   2,0,32'h22, 1, 0,1,0,1, 0, 0,     0);
      vecs[12] = mk(0, 0,0,0,        2,0,32'h22, 1, 1,1,0,1, 0, 0,     0);
      vecs[13] = mk(0, 0,0,0,        2,0,32'h22, 1, 1,1,1,0, 0, 0,     0);
      vecs[14] = mk(0, 0,0,0,        2,0,32'h22, 1, 1,0,0,1, 0, 0,     0);
      vecs[15] = mk(0, 1,0,0,        0,0,0,      1, 1,1,0,1, 0, 0,     0);
      vecs[16] = mk(0, 1,0,0,        0,0,0,      1, 1,1,1,1, 0, 0,     0);
      vecs[17] = mk(0, 1,0,0,        0,0,0,      1, 0,1,0,1, 0, 32'h22,0);
      vecs[18] = mk(0, 2,3,A,        0,0,0,      1, 1,1,0,1, 0, 32'h22,0);
      vecs[19] = mk(0, 2,3,A,        0,0,0,      1, 1,1,1,0, 3, 32'h22,0);
      vecs[20] = mk(0, 2,3,A,        0,0,0,      1, 0,1,0,1, 3, 32'h22,0);
      vecs[21] = mk(0, 0,0,0,        1,3,0,      1, 1,1,0,1, 3, 32'h22,0);
      vecs[22] = mk(0, 0,0,0,        1,3,0,      1, 1,1,1,1, 3, 32'h22,0);
      vecs[23] = mk(0, 0,0,0,        1,3,0,      1, 1,0,0,1, 3, 32'h22,A);
      vecs[24] = mk(0, 0,0,0,        3,1,7,      1, 1,1,0,1, 3, 32'h22,A);
      vecs[25] = mk(0, 0,0,0,        3,1,7,      1, 1,1,1,0, 1, 32'h22,A);
      vecs[26] = mk(0, 0,0,0,        3,1,7,      1, 1,0,0,1, 1, 32'h22,A);
      vecs[27] = mk(0, 0,0,0,        1,1,0,      1, 1,1,0,1, 1, 32'h22,A);
      vecs[28] = mk(0, 0,0,0,        1,1,0,      1, 1,1,1,1, 1, 32'h22,A);
      vecs[29] = mk(0, 0,0,0,        1,1,0,      1, 1,0,0,1, 1, 32'h22,7);
      vecs[30] = mk(0, 2,3,32'hFFFF, 0,0,0,      1, 1,1,0,1, 1, 32'h22,7);
      vecs[31] = mk(1, 2,3,32'hFFFF, 0,0,0,      1, 1,1,0,1, 3, 32'h22,7);
      vecs[32] = mk(0, 0,0,0,        0,0,0,      1, 1,1,0,1, 0, 0,     0);
      vecs[33] = mk(0, 1,3,0,        0,0,0,      1, 1,1,0,1, 0, 0,     0);
      vecs[34] = mk(0, 1,3,0,        0,0,0,      1, 1,1,1,1, 3, 0,     0);
      vecs[35] = mk(0, 1,3,0,        0,0,0,      1, 0,1,0,1, 3, A,     0);

      drive(1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      cyc = 0;

      for (int i = 0; i < 36; i++) begin
         drive(vecs[i].rst, vecs[i].op0, vecs[i].a0, vecs[i].d0, vecs[i].op1, vecs[i].a1, vecs[i].d1);
         #1;
         if (vecs[i].chk) begin
            chk($sformatf("vec%0d m0_waitrequest", i), {31'b0, m0_waitrequest}, {31'b0, vecs[i].ew0});
            chk($sformatf("vec%0d m1_waitrequest", i), {31'b0, m1_waitrequest}, {31'b0, vecs[i].ew1});
            chk($sformatf("vec%0d avs_chipselect", i), {31'b0, avs_chipselect}, {31'b0, vecs[i].ecs});
            chk($sformatf("vec%0d avs_write_n", i), {31'b0, avs_write_n}, {31'b0, vecs[i].ewn});
            chk($sformatf("vec%0d avs_address", i), {30'b0, avs_address}, {30'b0, vecs[i].eaddr});
            chk($sformatf("vec%0d m0_readdata", i), m0_readdata, vecs[i].erd0);
            chk($sformatf("vec%0d m1_readdata", i), m1_readdata, vecs[i].erd1);
         end
         $display("vec %0d: wr0=%0b wr1=%0b cs=%0b wn=%0b addr=%0d rd0=%h rd1=%h",
                  i, m0_waitrequest, m1_waitrequest, avs_chipselect, avs_write_n, avs_address,
                  m0_readdata, m1_readdata);
         tick();
      end
      chk("slave addr3 kept after aborted write", slave_mem[3], A);
      chk("slave addr1 after read+write", slave_mem[1], 32'h7);

      // Continuous contention: completions must alternate m0, m1, ... three cycles apart.
      drive(1, 0, 0, 0, 0, 0, 0);
      tick();
      drive(0, 2, 1, 32'h100, 2, 2, 32'h200);
      for (int k = 0; k < 40 && order.size() < 6; k++) begin
         #1;
         if (!m0_waitrequest) begin
            order.push_back(0); when.push_back(cyc);
            m0_writedata = m0_writedata + 1;
         end
         if (!m1_waitrequest) begin
            order.push_back(1); when.push_back(cyc);
            m1_writedata = m1_writedata + 1;
         end
         tick();
      end
      chk("alternation completions", order.size(), 6);
      for (int i = 0; i < order.size(); i++) begin
         chk($sformatf("alternation grant %0d", i), order[i], i % 2);
         if (i > 0) chk($sformatf("alternation spacing %0d", i), when[i] - when[i-1], 3);
         $display("alt %0d: requester m%0d done at cycle %0d", i, order[i], when[i]);
      end

      // Random traffic: requesters hold each command until they see waitrequest low.
      act[0] = 0; act[1] = 0;
      drive(0, 0, 0, 0, 0, 0, 0);
      for (int k = 0; k < 600; k++) begin
         for (int x = 0; x < 2; x++) begin
            if (!act[x] && $urandom_range(2, 0) == 0) begin
               act[x] = 1;
               rop[x] = 2'($urandom_range(3, 1));
               radr[x] = 2'($urandom_range(3, 0));
               rdat[x] = $urandom;
            end
         end
         drive(($urandom_range(79, 0) == 0), act[0] ? rop[0] : 2'b00, radr[0], rdat[0],
               act[1] ? rop[1] : 2'b00, radr[1], rdat[1]);
         #1;
         model_check();
         $display("rnd %0d: rst=%0b op0=%0d op1=%0d wr0=%0b wr1=%0b cs=%0b wn=%0b addr=%0d",
                  k, rst, m0_read | (m0_write << 1), m1_read | (m1_write << 1),
                  m0_waitrequest, m1_waitrequest, avs_chipselect, avs_write_n, avs_address);
         if (!m0_waitrequest) act[0] = 0;
         if (!m1_waitrequest) act[1] = 0;
         tick();
      end
      for (int i = 0; i < 4; i++) chk($sformatf("final slave mem %0d", i), slave_mem[i], m_mem[i]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
